// File: rtl/mac_seq.sv
// Operand sequencer and accumulator: walks a shared activation/weight address range,
// multiplies each returned pair, adds onto a bias and offers the sum on valid/ready.
module mac_seq #(
    parameter int N      = 16,
    parameter int LEN    = 784,
    parameter int ADDR_W = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [2*N-1:0]    bias_i,
    output logic              busy_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [N-1:0]      value_i,
    input  logic [N-1:0]      weight_i,
    output logic [2*N-1:0]    result_o,
    output logic              valid_o,
    input  logic              ready_i
);

    // Handshake: result_o is held stable while valid_o is high; the transfer
    // happens on the rising edge where valid_o && ready_i, then the block idles.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]    acc_q, acc_d;
    logic              pend_q, pend_d;
    logic [2*N-1:0]    prod;
    logic              start_acc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST) state_d = S_DRAIN;
            S_DRAIN: state_d = S_OUT;
            S_OUT:   if (ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state_q != S_IDLE);
        rd_en_o  = (state_q == S_RUN);
        addr_o   = rd_en_o ? cnt_q : '0;
        valid_o  = (state_q == S_OUT);
        result_o = valid_o ? acc_q : '0;
    end

    // Memory data arrives one cycle after its address, so pend marks that the
    // operands on value_i/weight_i this cycle belong to an issued read.
    assign prod      = {{N{1'b0}}, value_i} * {{N{1'b0}}, weight_i};
    assign start_acc = (state_q == S_IDLE) && start_i;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        pend_d = rd_en_o;
        if (start_acc) begin
            acc_d = bias_i;
            cnt_d = '0;
        end else if (pend_q) begin
            acc_d = acc_q + prod;
        end
        if (state_q == S_RUN) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: LEN=4 and LEN=1 instances fed by registered-read
// memory models, results checked against a queue of expected sums.
module tb_mac_seq;

    localparam int N   = 8;
    localparam int LEN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           start, start1;
    logic [2*N-1:0] bias, bias1;
    logic           busy, busy1, rd_en, rd_en1, valid, valid1;
    logic [1:0]     addr;
    logic [0:0]     addr1;
    logic [N-1:0]   value = '0, weight = '0, value1 = '0, weight1 = '0;
    logic [2*N-1:0] result, result1;
    logic           ready, ready1;

    logic [N-1:0]   mem_v [LEN];
    logic [N-1:0]   mem_w [LEN];
    logic [N-1:0]   v1, w1;

    logic [2*N-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    mac_seq #(.N(N), .LEN(LEN)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bias_i(bias),
        .busy_o(busy), .rd_en_o(rd_en), .addr_o(addr),
        .value_i(value), .weight_i(weight),
        .result_o(result), .valid_o(valid), .ready_i(ready)
    );

    mac_seq #(.N(N), .LEN(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .bias_i(bias1),
        .busy_o(busy1), .rd_en_o(rd_en1), .addr_o(addr1),
        .value_i(value1), .weight_i(weight1),
        .result_o(result1), .valid_o(valid1), .ready_i(ready1)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            value  <= mem_v[addr];
            weight <= mem_w[addr];
        end
        if (rd_en1) begin
            value1  <= v1;
            weight1 <= w1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] model_dot(input logic [2*N-1:0] b);
        logic [2*N-1:0] s;
        s = b;
        for (int k = 0; k < LEN; k++) s = s + (2*N)'(mem_v[k]) * (2*N)'(mem_w[k]);
        return s;
    endfunction

    task automatic load_mem(input int kind);
        for (int k = 0; k < LEN; k++) begin
            case (kind)
                0: begin mem_v[k] = N'(k + 1); mem_w[k] = N'(k + 5); end
                1: begin mem_v[k] = 8'hFF;     mem_w[k] = 8'hFF;     end
                default: begin mem_v[k] = 8'd1; mem_w[k] = 8'd1;     end
            endcase
        end
    endtask

    task automatic start_run(input logic [2*N-1:0] b);
        bias  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_rd_en"},  32'(rd_en),  32'd0);
        check({tag, "_addr"},   32'(addr),   32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_valid"},  32'(valid),  32'd0);
    endtask

    // Called in cycle cyc0 after the start edge; waits for valid and scores the result.
    task automatic wait_valid(input string tag, input int cyc0, input int exp_lat);
        int n;
        logic [2*N-1:0] e;
        n = cyc0;
        while (valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_result"}, 32'(result), 32'(e));
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        bias   = '0;
        bias1  = '0;
        ready  = 1'b1;
        ready1 = 1'b1;
        v1     = '0;
        w1     = '0;
        load_mem(0);
        repeat (2) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic: addresses 0..3 on consecutive cycles, 80 after LEN+2 cycles
        exp_q.push_back(model_dot(16'd10));
        start_run(16'd10);
        for (int k = 0; k < LEN; k++) begin
            check("basic_rd_en", 32'(rd_en), 32'd1);
            check("basic_addr",  32'(addr),  32'(k));
            tick();
        end
        check("basic_drain_rd_en", 32'(rd_en), 32'd0);
        wait_valid("basic", LEN + 1, LEN + 2);
        check("basic_const", 32'(result), 32'd80);
        tick();
        check("basic_idle_busy",  32'(busy),  32'd0);
        check("basic_idle_valid", 32'(valid), 32'd0);

        // Wrap modulo 2^16
        load_mem(1);
        exp_q.push_back(model_dot(16'd0));
        start_run(16'd0);
        wait_valid("wrap", 1, LEN + 2);
        check("wrap_const", 32'(result), 32'h0000F804);
        tick();

        // Back-pressure with an ignored start pulse while held in OUT
        load_mem(0);
        ready = 1'b0;
        exp_q.push_back(model_dot(16'd10));
        start_run(16'd10);
        wait_valid("bp", 1, LEN + 2);
        for (int i = 0; i < 10; i++) begin
            check("bp_result", 32'(result), 32'd80);
            check("bp_valid",  32'(valid),  32'd1);
            check("bp_busy",   32'(busy),   32'd1);
            check("bp_rd_en",  32'(rd_en),  32'd0);
            start = (i == 3);
            tick();
        end
        start = 1'b0;
        check("bp_still_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        tick();
        check("bp_idle_busy",  32'(busy),  32'd0);
        check("bp_idle_valid", 32'(valid), 32'd0);
        tick();
        check("bp_no_queued_start", 32'(busy), 32'd0);

        // Reset on the third RUN cycle, then a clean restart
        start_run(16'd10);
        tick();
        tick();
        check("rst_run_addr", 32'(addr), 32'd2);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        tick();
        check_outputs_zero("rst_held");
        rst_n = 1'b1;
        tick();
        load_mem(2);
        exp_q.push_back(model_dot(16'd0));
        start_run(16'd0);
        wait_valid("rst_rerun", 1, LEN + 2);
        check("rst_rerun_const", 32'(result), 32'd4);
        tick();

        // Start during the OUT handshake is dropped; one cycle later it is taken
        load_mem(0);
        exp_q.push_back(model_dot(16'd10));
        start_run(16'd10);
        wait_valid("coll", 1, LEN + 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("coll_idle_busy",  32'(busy),  32'd0);
        check("coll_idle_rd_en", 32'(rd_en), 32'd0);
        exp_q.push_back(model_dot(16'd10));
        start_run(16'd10);
        check("coll_restart_busy", 32'(busy), 32'd1);
        wait_valid("coll_restart", 1, LEN + 2);
        tick();

        // LEN=1 instance
        begin
            int n;
            v1 = 8'd7;
            w1 = 8'd9;
            exp_q.push_back(16'd3 + 16'(v1) * 16'(w1));
            bias1  = 16'd3;
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check("len1_rd_en", 32'(rd_en1), 32'd1);
            n = 1;
            while (valid1 !== 1'b1 && n < 20) begin
                check("len1_addr", 32'(addr1), 32'd0);
                tick();
                n++;
            end
            check("len1_latency", 32'(n), 32'd3);
            check("len1_result", 32'(result1), 32'(exp_q.pop_front()));
            check("len1_const",  32'(result1), 32'd66);
            tick();
            check("len1_idle_busy", 32'(busy1), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
